// File: rtl/abc_window_seq_gen_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// abc_seq_pkg : shared state encoding and default widths
// Rev 1.0
// ------------------------------------------------------------------
package abc_seq_pkg;

  localparam int DEFAULT_LEN_W   = 4;
  localparam int DEFAULT_TRAIL_W = 3;
  localparam int DEFAULT_DEF_LEN = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BMARK  = 2'd1,
    CBURST = 2'd2,
    TRAIL  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/abc_window_seq_gen_if.sv
`default_nettype none
// ------------------------------------------------------------------
// abc_window_seq_gen_if : request inputs and a/b/c window outputs
// Rev 1.0
// ------------------------------------------------------------------
interface abc_window_seq_gen_if #(
  parameter int LEN_W   = 4,
  parameter int TRAIL_W = 3
);
  logic               start_i;
  logic [LEN_W-1:0]   burst_len_i;
  logic [TRAIL_W-1:0] trail_i;
  logic               abort_i;
  logic               a_o;
  logic               b_o;
  logic               c_o;
  logic               busy_o;
  logic               done_o;
  logic               aborted_o;

  modport master (
    output start_i, burst_len_i, trail_i, abort_i,
    input  a_o, b_o, c_o, busy_o, done_o, aborted_o
  );

  modport slave (
    input  start_i, burst_len_i, trail_i, abort_i,
    output a_o, b_o, c_o, busy_o, done_o, aborted_o
  );
endinterface
`default_nettype wire

// File: rtl/abc_window_seq_gen_seq_down_cnt.sv
`default_nettype none
// ------------------------------------------------------------------
// seq_down_cnt : loadable down counter with last/zero flags
// Rev 1.0
// ------------------------------------------------------------------
module seq_down_cnt #(
  parameter int WIDTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_val,
  input  wire logic             dec,
  output logic                  last,
  output logic                  zero
);

  logic [WIDTH-1:0] count;

  // Decrement saturates at zero so the count can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == WIDTH'(1));
  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/abc_window_seq_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// abc_window_seq_gen : drives a window, b marker, c burst, trailing a
// Rev 1.0
// ------------------------------------------------------------------
module abc_window_seq_gen
  import abc_seq_pkg::*;
#(
  parameter int LEN_W   = DEFAULT_LEN_W,
  parameter int TRAIL_W = DEFAULT_TRAIL_W,
  parameter int DEF_LEN = DEFAULT_DEF_LEN
) (
  input wire logic clk,
  input wire logic rst,
  abc_window_seq_gen_if.slave bus
);

  localparam logic [LEN_W-1:0] DEF_LEN_V = LEN_W'(DEF_LEN);

  state_t           state, next_state;
  logic [LEN_W-1:0] len_sel;
  logic             burst_load, burst_dec, burst_last, burst_zero;
  logic             trail_load, trail_dec, trail_last, trail_zero;
  logic             done_next, abort_next;
  logic             a_q, b_q, c_q, busy_q, done_q, aborted_q;

  assign len_sel = (bus.burst_len_i == '0) ? DEF_LEN_V : bus.burst_len_i;

  seq_down_cnt #(.WIDTH(LEN_W)) u_burst_cnt (
    .clk(clk), .rst(rst),
    .load(burst_load), .load_val(len_sel), .dec(burst_dec),
    .last(burst_last), .zero(burst_zero)
  );

  seq_down_cnt #(.WIDTH(TRAIL_W)) u_trail_cnt (
    .clk(clk), .rst(rst),
    .load(trail_load), .load_val(bus.trail_i), .dec(trail_dec),
    .last(trail_last), .zero(trail_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Both counters load at the accepted start, which doubles as the latch.
  always_comb begin
    next_state = state;
    burst_load = 1'b0;
    trail_load = 1'b0;
    burst_dec  = 1'b0;
    trail_dec  = 1'b0;
    done_next  = 1'b0;
    abort_next = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          next_state = BMARK;
          burst_load = 1'b1;
          trail_load = 1'b1;
        end
      end
      BMARK: begin
        if (bus.abort_i) begin
          next_state = IDLE;
          abort_next = 1'b1;
        end else begin
          next_state = CBURST;
        end
      end
      CBURST: begin
        if (bus.abort_i) begin
          next_state = IDLE;
          abort_next = 1'b1;
        end else begin
          burst_dec = 1'b1;
          if (burst_last || burst_zero) begin
            if (trail_zero) begin
              next_state = IDLE;
              done_next  = 1'b1;
            end else begin
              next_state = TRAIL;
            end
          end
        end
      end
      TRAIL: begin
        if (bus.abort_i) begin
          next_state = IDLE;
          abort_next = 1'b1;
        end else begin
          trail_dec = 1'b1;
          if (trail_last || trail_zero) begin
            next_state = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state so edges are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      c_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      a_q       <= (next_state != IDLE);
      b_q       <= (next_state == BMARK);
      c_q       <= (next_state == CBURST);
      busy_q    <= (next_state != IDLE);
      done_q    <= done_next;
      aborted_q <= abort_next;
    end
  end

  assign bus.a_o       = a_q;
  assign bus.b_o       = b_q;
  assign bus.c_o       = c_q;
  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.aborted_o = aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_abc_window_seq_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_abc_window_seq_gen : per-cycle scoreboard against a transaction model
// Rev 1.0
// ------------------------------------------------------------------
module tb_abc_window_seq_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  abc_window_seq_gen_if #(.LEN_W(4), .TRAIL_W(3)) bus ();

  abc_window_seq_gen #(.LEN_W(4), .TRAIL_W(3), .DEF_LEN(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [5:0] exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  bit         mon_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] obs();
    return {bus.a_o, bus.b_o, bus.c_o, bus.busy_o, bus.done_o, bus.aborted_o};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: a/b/c/busy/done/aborted got %b, expected %b",
               name, cyc, act, exp);
    end
  endtask

  // Monitor: one expected vector per cycle, popped mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL underflow cycle %0d: got %b, expected an entry queued", cyc, obs());
      end else begin
        check("cycle", obs(), exp_q.pop_front());
      end
    end
  end

  task automatic push(input bit a, input bit b, input bit c, input bit busy,
                      input bit done, input bit ab);
    exp_q.push_back({a, b, c, busy, done, ab});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      next_cycle();
      push(0, 0, 0, 0, 0, 0);
      bus.start_i     = 1'b0;
      bus.abort_i     = 1'($urandom);
      bus.burst_len_i = 4'($urandom);
      bus.trail_i     = 3'($urandom);
    end
  endtask

  // Transaction model: 1 marker cycle, L burst cycles, R trail cycles, then a
  // completion cycle; abort in cycle k ends the window after cycle k.
  // start_mode: 0 low while busy, 1 random while busy, 2 held high.
  task automatic txn(input int len_in, input int trl, input int abort_off, input int start_mode);
    int L, n;
    bit aborted;
    L       = (len_in == 0) ? 2 : len_in;
    n       = 1 + L + trl;
    aborted = 1'b0;
    bus.start_i     = 1'b1;
    bus.burst_len_i = 4'(len_in);
    bus.trail_i     = 3'(trl);
    bus.abort_i     = 1'($urandom);
    for (int i = 1; i <= n; i++) begin
      next_cycle();
      push(1, i == 1, (i >= 2) && (i <= 1 + L), 1, 0, 0);
      bus.start_i     = (start_mode == 2) ? 1'b1 :
                        (start_mode == 1) ? 1'($urandom) : 1'b0;
      bus.burst_len_i = 4'($urandom);
      bus.trail_i     = 3'($urandom);
      bus.abort_i     = (i == abort_off);
      if (i == abort_off) begin
        aborted = 1'b1;
        break;
      end
    end
    next_cycle();
    push(0, 0, 0, 0, !aborted, aborted);
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
  endtask

  initial begin
    int L, T, n;
    rst             = 1'b1;
    bus.start_i     = 1'b0;
    bus.burst_len_i = '0;
    bus.trail_i     = '0;
    bus.abort_i     = 1'b0;
    #12;
    check("reset_state", obs(), 6'b000000);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    push(0, 0, 0, 0, 0, 0);

    txn(2, 0, 0, 0);   idle(2);
    txn(2, 1, 0, 0);   idle(1);
    txn(0, 0, 0, 0);   idle(1);
    txn(15, 7, 0, 1);  idle(1);
    txn(2, 0, 2, 0);   idle(2);
    txn(3, 2, 0, 2);
    txn(1, 0, 0, 2);
    txn(4, 1, 0, 1);   idle(1);
    txn(5, 3, 1, 0);   idle(1);
    txn(2, 2, 5, 0);   idle(1);
    txn(3, 0, 4, 0);   idle(1);

    // Asynchronous reset in the middle of a burst.
    next_cycle();
    mon_en          = 1'b0;
    bus.start_i     = 1'b1;
    bus.abort_i     = 1'b0;
    bus.burst_len_i = 4'd5;
    bus.trail_i     = 3'd0;
    next_cycle();
    bus.start_i = 1'b0;
    next_cycle();
    next_cycle();
    check("pre_reset_burst", obs(), 6'b101100);
    #2 rst = 1'b1;
    #1 check("async_reset", obs(), 6'b000000);
    next_cycle();
    check("reset_hold", obs(), 6'b000000);
    rst = 1'b0;
    next_cycle();
    mon_en = 1'b1;
    push(0, 0, 0, 0, 0, 0);
    txn(2, 0, 0, 0);   idle(1);

    for (int k = 0; k < 40; k++) begin
      L = $urandom_range(0, 15);
      T = $urandom_range(0, 7);
      n = 1 + ((L == 0) ? 2 : L) + T;
      txn(L, T, ($urandom_range(0, 4) == 0) ? $urandom_range(1, n) : 0,
          $urandom_range(0, 2));
      idle($urandom_range(0, 2));
    end

    idle(2);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
